// File: rtl/captcha_sequence_checker.sv
// -----------------------------------------------------------------------------
// captcha_sequence_checker
//
// Builds a CAPTCHA challenge of SEQ_LEN symbols (0..5) from a random symbol
// stream, presents the symbols one at a time and checks user button entries
// against them. Wrong entries and per-symbol idle timeouts consume tries. When
// all tries are used the block reports fail. When the whole sequence is
// entered correctly it reports pass.
//
// Parameters:
//   SEQ_LEN    symbols per challenge (2..7)
//   MAX_TRIES  wrong entries allowed before fail (1..3)
//   TIMEOUT    idle WAIT cycles per symbol before an automatic wrong entry
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-high reset, forces IDLE
//   start         in   single-cycle request to begin/restart (IDLE/PASS/FAIL)
//   rand_sym      in   [2:0] random symbol, one captured per GEN cycle
//   btn_valid     in   single-cycle pulse: user entry present
//   btn_code      in   [2:0] user-entered symbol
//   symbol        out  [2:0] currently expected symbol (WAIT only, else 0)
//   symbol_valid  out  high in WAIT
//   progress      out  [2:0] correctly entered symbols in this attempt
//   tries_used    out  [1:0] wrong entries so far
//   busy          out  high in GEN or WAIT
//   pass          out  high in PASS
//   fail          out  high in FAIL
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module captcha_sequence_checker #(
    parameter int SEQ_LEN   = 4,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] rand_sym,
    input  logic       btn_valid,
    input  logic [2:0] btn_code,
    output logic [2:0] symbol,
    output logic       symbol_valid,
    output logic [2:0] progress,
    output logic [1:0] tries_used,
    output logic       busy,
    output logic       pass,
    output logic       fail
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_GEN  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_PASS = 3'd3;
    localparam logic [2:0] ST_FAIL = 3'd4;

    localparam int              CNT_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       LAST_IDX   = 3'(SEQ_LEN - 1);
    localparam logic [2:0]       SEQ_LEN_C  = 3'(SEQ_LEN);
    localparam logic [1:0]       MAX_TRIES_C = 2'(MAX_TRIES);

    // Fold 6/7 onto 0/1, then bump by one (mod 6) if the result would repeat
    // the previously captured symbol.
    function automatic logic [2:0] fix_sym(
        input logic [2:0] raw,
        input logic [2:0] prev,
        input logic       has_prev
    );
        logic [2:0] folded;
        logic [2:0] bumped;
        folded = (raw >= 3'd6) ? (raw - 3'd6) : raw;
        bumped = (folded == 3'd5) ? 3'd0 : (folded + 3'd1);
        if (has_prev && (folded == prev)) begin
            return bumped;
        end else begin
            return folded;
        end
    endfunction

    // The array is sized to the full 3-bit index range so every index is legal;
    // only the first SEQ_LEN entries are ever written or read.
    logic [2:0]       seq_r [0:7];
    logic [2:0]       state_r;
    logic [2:0]       gen_idx_r;
    logic [CNT_W-1:0] idle_cnt_r;
    logic [2:0]       progress_r;
    logic [1:0]       tries_r;
    logic [2:0]       symbol_r;
    logic             symbol_valid_r;
    logic             busy_r;
    logic             pass_r;
    logic             fail_r;

    logic [2:0]       state_s;
    logic [2:0]       gen_idx_s;
    logic [CNT_W-1:0] idle_cnt_s;
    logic [2:0]       progress_s;
    logic [1:0]       tries_s;
    logic [2:0]       symbol_s;
    logic             seq_we_s;
    logic [2:0]       seq_wdata_s;
    logic             wrong_s;

    // Next-state, datapath and sequence-write decode.
    always_comb begin
        state_s     = state_r;
        gen_idx_s   = gen_idx_r;
        idle_cnt_s  = idle_cnt_r;
        progress_s  = progress_r;
        tries_s     = tries_r;
        symbol_s    = 3'd0;
        seq_we_s    = 1'b0;
        wrong_s     = 1'b0;
        // gen_idx_r - 1 wraps to 7 at index 0, which is harmless: has_prev is 0.
        seq_wdata_s = fix_sym(rand_sym, seq_r[gen_idx_r - 3'd1], (gen_idx_r != 3'd0));

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_GEN;
                    gen_idx_s  = 3'd0;
                    progress_s = 3'd0;
                    idle_cnt_s = CNT_ZERO;
                    tries_s    = 2'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_GEN: begin
                seq_we_s = 1'b1;
                if (gen_idx_r == LAST_IDX) begin
                    state_s    = ST_WAIT;
                    idle_cnt_s = CNT_ZERO;
                    // seq_r[0] is already stored unless it is being written now.
                    symbol_s   = (gen_idx_r == 3'd0) ? seq_wdata_s : seq_r[3'd0];
                end else begin
                    gen_idx_s = gen_idx_r + 3'd1;
                end
            end

            ST_WAIT: begin
                symbol_s = symbol_r;
                // A button press on the expiry cycle takes priority over the timeout.
                if (btn_valid) begin
                    if (btn_code == symbol_r) begin
                        progress_s = progress_r + 3'd1;
                        idle_cnt_s = CNT_ZERO;
                        if (progress_s == SEQ_LEN_C) begin
                            state_s  = ST_PASS;
                            symbol_s = 3'd0;
                        end else begin
                            symbol_s = seq_r[progress_s];
                        end
                    end else begin
                        wrong_s = 1'b1;
                    end
                end else if (idle_cnt_r == IDLE_LAST) begin
                    wrong_s = 1'b1;
                end else begin
                    idle_cnt_s = idle_cnt_r + CNT_ONE;
                end

                if (wrong_s) begin
                    tries_s  = tries_r + 2'd1;
                    symbol_s = 3'd0;
                    if (tries_s == MAX_TRIES_C) begin
                        state_s = ST_FAIL;
                    end else begin
                        state_s    = ST_GEN;
                        gen_idx_s  = 3'd0;
                        progress_s = 3'd0;
                        idle_cnt_s = CNT_ZERO;
                    end
                end else begin
                    tries_s = tries_r;
                end
            end

            ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_s    = ST_GEN;
                    gen_idx_s  = 3'd0;
                    progress_s = 3'd0;
                    idle_cnt_s = CNT_ZERO;
                    tries_s    = 2'd0;
                end else begin
                    state_s = state_r;
                end
            end

            default: begin
                state_s    = ST_IDLE;
                gen_idx_s  = 3'd0;
                progress_s = 3'd0;
                idle_cnt_s = CNT_ZERO;
                tries_s    = 2'd0;
            end
        endcase
    end

    // State, sequence storage and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                seq_r[i] <= 3'd0;
            end
            state_r        <= ST_IDLE;
            gen_idx_r      <= 3'd0;
            idle_cnt_r     <= CNT_ZERO;
            progress_r     <= 3'd0;
            tries_r        <= 2'd0;
            symbol_r       <= 3'd0;
            symbol_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            pass_r         <= 1'b0;
            fail_r         <= 1'b0;
        end else begin
            if (seq_we_s) begin
                seq_r[gen_idx_r] <= seq_wdata_s;
            end
            state_r        <= state_s;
            gen_idx_r      <= gen_idx_s;
            idle_cnt_r     <= idle_cnt_s;
            progress_r     <= progress_s;
            tries_r        <= tries_s;
            symbol_r       <= symbol_s;
            symbol_valid_r <= (state_s == ST_WAIT);
            busy_r         <= (state_s == ST_GEN) || (state_s == ST_WAIT);
            pass_r         <= (state_s == ST_PASS);
            fail_r         <= (state_s == ST_FAIL);
        end
    end

    assign symbol       = symbol_r;
    assign symbol_valid = symbol_valid_r;
    assign progress     = progress_r;
    assign tries_used   = tries_r;
    assign busy         = busy_r;
    assign pass         = pass_r;
    assign fail         = fail_r;

endmodule

// File: doc/captcha_sequence_checker.md
Name: captcha_sequence_checker

Overview:
Consumes the 0..5 random symbol stream from the random finger generator and builds a CAPTCHA challenge of SEQ_LEN symbols. It presents the symbols one at a time and checks each user button entry against the expected symbol. It also tracks retries and an idle timeout. It reports pass or fail to the top-level game/OLED control.

Parameters:
SEQ_LEN, 4, symbols per challenge (legal range 2..7)
MAX_TRIES, 3, wrong entries allowed before fail (legal range 1..3)
TIMEOUT, 100000000, idle cycles per symbol before an automatic wrong entry (1 s at 100 MHz)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces IDLE
start  in  1  single-cycle request to begin or restart a challenge
rand_sym  in  3  random symbol from the generator, sampled every GEN cycle
btn_valid  in  1  single-cycle pulse: user entry present
btn_code  in  3  user-entered symbol (0..5)
symbol  out  3  currently expected symbol, for display
symbol_valid  out  1  high in WAIT only
progress  out  3  count of correctly entered symbols in the current attempt
tries_used  out  2  wrong entries so far
busy  out  1  high in GEN or WAIT
pass  out  1  high in PASS
fail  out  1  high in FAIL

Behaviour:
- Reset (async): state=IDLE. All outputs 0. Sequence RAM, gen_idx, idle counter and tries cleared.
- States and outputs:
  - IDLE: all outputs 0.
  - GEN: busy=1.
  - WAIT: busy=1, symbol_valid=1, symbol=seq[progress].
  - PASS: pass=1, latched.
  - FAIL: fail=1, latched.
- IDLE -> GEN on start. PASS/FAIL -> GEN on start, which also clears tries_used. start is ignored in GEN/WAIT.
- GEN sampling:
  - One symbol is captured per cycle: seq[gen_idx] <= fix(rand_sym); gen_idx++.
  - Exactly SEQ_LEN cycles, then WAIT.
  - On GEN entry: gen_idx=0, progress=0, idle counter=0.
- fix() rules, in order:
  - Fold: values 6 and 7 map to 0 and 1.
  - No repeats: if gen_idx>0 and the folded value equals seq[gen_idx-1], replace it with (value+1) mod 6.
- WAIT, btn_valid with btn_code==symbol:
  - progress++ and idle counter cleared.
  - If the new progress==SEQ_LEN, go to PASS.
  - Update is visible the cycle after the pulse.
- WAIT, wrong entry (btn_valid with a mismatching code, or the idle counter reaching TIMEOUT-1):
  - tries_used++.
  - If the new tries_used==MAX_TRIES, go to FAIL. Otherwise go to GEN, which builds a fresh sequence.
- Idle counter:
  - Increments every WAIT cycle without btn_valid.
  - If btn_valid and timeout expiry occur in the same cycle, the button wins and the timeout is not counted.
- btn_valid outside WAIT is ignored.
- In PASS/FAIL, progress and tries_used hold their final values until start.
- Reset mid-GEN/WAIT aborts immediately. Nothing from the old challenge is visible afterwards.
- All outputs are registered, with no combinational path from inputs to outputs.
- btn_code 6/7 never matches.

Test Plan:
- Reset, start, rand_sym=2,4,1,5 across the 4 GEN cycles -> WAIT with symbol=2. Enter 2,4,1,5 -> progress steps 1,2,3, then pass=1 one cycle after the 4th pulse. busy=0, tries_used=0.
- rand_sym=7,3,3,5 -> seq=1,3,4,5 (fold, then repeat bump). rand_sym=5,5,0,0 -> 5,0,1,0.
- WAIT on symbol=2, enter 3 -> tries_used=1, state=GEN, progress=0. New sequence is accepted with the next rand_sym values.
- MAX_TRIES=3 with three wrong entries -> fail=1, tries_used=3. Further btn_valid has no effect. start -> GEN with tries_used=0.
- TIMEOUT=10: no input for 10 WAIT cycles -> tries_used=1 and regenerate. btn_valid (correct) on the expiry cycle -> progress=1, tries_used unchanged.
- Assert reset mid-WAIT with progress=2 -> next cycle all outputs 0, IDLE. btn_valid is ignored until start.
